// File: rtl/msu_seq_multiplier.sv
// Iterative handshaked multiplier: redundant-form operands in, carry-save product out.
// Optional macro MSU_MUL_FINAL_ADD_EN adds a carry-propagate cycle producing (sum, 0).
module msu_seq_multiplier #(
    parameter int unsigned WordBits     = 16,
    parameter int unsigned NumElements  = 8,
    parameter int unsigned ColsPerCycle = 2,
    localparam int unsigned OpBits    = (NumElements + 1) * WordBits,
    localparam int unsigned ResBits   = 2 * OpBits,
    localparam int unsigned DigitBits = ColsPerCycle * WordBits,
    localparam int unsigned Iters     = (NumElements + ColsPerCycle) / ColsPerCycle,
    localparam int unsigned PadBits   = Iters * DigitBits,
    localparam int unsigned KW        = $clog2(Iters + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [OpBits-1:0]  nr_a_i,
    input  logic [OpBits-1:0]  r_a_i,
    input  logic [OpBits-1:0]  nr_b_i,
    input  logic [OpBits-1:0]  r_b_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [ResBits-1:0] part_nr_o,
    output logic [ResBits-1:0] part_r_o
);

    typedef enum logic [1:0] {StIdle, StMul, StAdd, StDone} state_e;

    state_e               state_q;
    logic [OpBits-1:0]    a_q;
    logic [PadBits-1:0]   b_q;
    logic [ResBits-1:0]   pp_q;
    logic [ResBits-1:0]   sum_q;
    logic [ResBits-1:0]   carry_q;
    logic [KW-1:0]        k_q;
    logic                 in_ready_q;
    logic                 out_valid_q;

    logic [OpBits-1:0]           a_sum;
    logic [OpBits-1:0]           b_sum;
    logic [DigitBits-1:0]        digit;
    logic [OpBits+DigitBits-1:0] prod;
    logic [ResBits-1:0]          pp_d;
    logic [ResBits-1:0]          sum_d;
    logic [ResBits-1:0]          carry_d;

    always_comb begin
        a_sum = nr_a_i + r_a_i;
        b_sum = nr_b_i + r_b_i;
        digit = '0;
        prod  = '0;
        pp_d  = '0;
        // Partial product is registered one cycle ahead of the compressor that consumes it;
        // the extra MUL cycle (k == Iters) drains the last one.
        if (k_q < KW'(Iters)) begin
            digit = b_q[int'(k_q) * DigitBits +: DigitBits];
            prod  = {{DigitBits{1'b0}}, a_q} * {{OpBits{1'b0}}, digit};
            pp_d  = ResBits'(prod) << (int'(k_q) * DigitBits);
        end
        sum_d   = sum_q ^ carry_q ^ pp_q;
        carry_d = ((sum_q & carry_q) | (sum_q & pp_q) | (carry_q & pp_q)) << 1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            pp_q        <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        a_q        <= a_sum;
                        b_q        <= PadBits'(b_sum);
                        pp_q       <= '0;
                        sum_q      <= '0;
                        carry_q    <= '0;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StMul;
                    end
                end
                StMul: begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    pp_q    <= pp_d;
                    k_q     <= k_q + 1'b1;
                    if (k_q == KW'(Iters)) begin
`ifdef MSU_MUL_FINAL_ADD_EN
                        state_q     <= StAdd;
`else
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
`endif
                    end
                end
`ifdef MSU_MUL_FINAL_ADD_EN
                StAdd: begin
                    sum_q       <= sum_q + carry_q;
                    carry_q     <= '0;
                    state_q     <= StDone;
                    out_valid_q <= 1'b1;
                end
`endif
                StDone: begin
                    if (out_ready_i) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign part_nr_o   = sum_q;
    assign part_r_o    = carry_q;

endmodule

// File: tb/tb_msu_seq_multiplier.sv
// Self-checking bench for msu_seq_multiplier: default build plus a single-iteration
// (ColsPerCycle=9) instance, both checked against a plain-arithmetic product model.
module tb_msu_seq_multiplier;

    localparam int OP  = 144;
    localparam int RES = 288;
`ifdef MSU_MUL_FINAL_ADD_EN
    localparam int LAT0 = 7;
    localparam int LAT1 = 3;
`else
    localparam int LAT0 = 6;
    localparam int LAT1 = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b0;
    logic           in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b0;
    logic [OP-1:0]  nr_a0 = '0, r_a0 = '0, nr_b0 = '0, r_b0 = '0;
    logic [RES-1:0] part_nr0, part_r0;
    logic           in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1;
    logic [OP-1:0]  nr_a1 = '0, r_a1 = '0, nr_b1 = '0, r_b1 = '0;
    logic [RES-1:0] part_nr1, part_r1;

    int tests = 0;
    int fails = 0;

    msu_seq_multiplier dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid0), .in_ready_o(in_ready0),
        .nr_a_i(nr_a0), .r_a_i(r_a0), .nr_b_i(nr_b0), .r_b_i(r_b0),
        .out_valid_o(out_valid0), .out_ready_i(out_ready0),
        .part_nr_o(part_nr0), .part_r_o(part_r0)
    );

    msu_seq_multiplier #(.ColsPerCycle(9)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .nr_a_i(nr_a1), .r_a_i(r_a1), .nr_b_i(nr_b1), .r_b_i(r_b1),
        .out_valid_o(out_valid1), .out_ready_i(out_ready1),
        .part_nr_o(part_nr1), .part_r_o(part_r1)
    );

    task automatic check(input string tag, input logic [RES-1:0] obs, input logic [RES-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: value the redundant pair represents, multiplied with plain arithmetic.
    function automatic logic [RES-1:0] model(input logic [OP-1:0] na, input logic [OP-1:0] ra,
                                             input logic [OP-1:0] nb, input logic [OP-1:0] rb);
        logic [OP-1:0]  a;
        logic [OP-1:0]  b;
        logic [RES-1:0] ae;
        logic [RES-1:0] be;
        a  = na + ra;
        b  = nb + rb;
        ae = RES'(a);
        be = RES'(b);
        return ae * be;
    endfunction

    function automatic logic [OP-1:0] rnd_nr();
        logic [OP-1:0] v;
        for (int i = 0; i < 9; i++) v[i*16 +: 16] = 16'($urandom);
        v[OP-1] = 1'b0;
        return v;
    endfunction

    function automatic logic [OP-1:0] rnd_r();
        logic [OP-1:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[(i+1)*16] = 1'($urandom);
        return v;
    endfunction

    task automatic op0(input string tag, input logic [OP-1:0] na, input logic [OP-1:0] ra,
                       input logic [OP-1:0] nb, input logic [OP-1:0] rb, input int hold);
        int             cnt;
        logic [RES-1:0] exp, tot, snap_nr, snap_r;
        logic           stable;
        exp = model(na, ra, nb, rb);
        nr_a0 = na; r_a0 = ra; nr_b0 = nb; r_b0 = rb;
        cnt = 0;
        while (!in_ready0 && cnt < 20) begin @(posedge clk); #1; cnt++; end
        check({tag, " ready"}, RES'(in_ready0), RES'(1));
        in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        nr_a0 = rnd_nr(); r_a0 = rnd_r(); nr_b0 = rnd_nr(); r_b0 = rnd_r();
        cnt = 0;
        while (!out_valid0 && cnt < 20) begin @(posedge clk); #1; cnt++; end
        check({tag, " latency"}, RES'(cnt), RES'(LAT0));
        tot = part_nr0 + part_r0;
        check({tag, " product"}, tot, exp);
`ifdef MSU_MUL_FINAL_ADD_EN
        check({tag, " carry zero"}, part_r0, '0);
`endif
        snap_nr = part_nr0;
        snap_r  = part_r0;
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (part_nr0 !== snap_nr || part_r0 !== snap_r || in_ready0 !== 1'b0 ||
                    out_valid0 !== 1'b1) stable = 1'b0;
            end
            check({tag, " hold"}, RES'(stable), RES'(1));
        end
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        out_ready0 = 1'b0;
        check({tag, " valid drop"}, RES'(out_valid0), RES'(0));
        check({tag, " idle part_nr"}, part_nr0, snap_nr);
    endtask

    initial begin
        logic [OP-1:0] all_nr, all_r, na, ra, nb, rb;
        logic [RES-1:0] exp, tot;
        int cnt;

        // Reset state
        #2 rst = 1'b1;
        #6;
        check("rst in_ready", RES'(in_ready0), RES'(1));
        check("rst out_valid", RES'(out_valid0), RES'(0));
        check("rst part_nr", part_nr0, '0);
        check("rst part_r", part_r0, '0);
        #4 rst = 1'b0;
        @(posedge clk); #1;

        op0("t1 3x5", OP'(3), '0, OP'(5), '0, 0);

        all_nr = '1;
        all_r  = '0;
        for (int i = 0; i < 8; i++) all_r[(i+1)*16] = 1'b1;
        op0("t2 all ones", all_nr, all_r, all_nr, all_r, 0);

        op0("t3 a zero", '0, '0, rnd_nr(), rnd_r(), 0);
        check("t3 carry", part_r0, '0);

        op0("t4 backpressure", rnd_nr(), rnd_r(), rnd_nr(), rnd_r(), 10);

        // Reset while in MUL at k=2
        nr_a0 = rnd_nr(); r_a0 = rnd_r(); nr_b0 = rnd_nr(); r_b0 = rnd_r();
        in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("t5 rst part_nr", part_nr0, '0);
        check("t5 rst part_r", part_r0, '0);
        check("t5 rst in_ready", RES'(in_ready0), RES'(1));
        check("t5 rst out_valid", RES'(out_valid0), RES'(0));
        #2 rst = 1'b0;
        @(posedge clk); #1;
        op0("t5 7x9", OP'(7), '0, OP'(9), '0, 0);

        for (int n = 0; n < 12; n++) op0("rand", rnd_nr(), rnd_r(), rnd_nr(), rnd_r(), n % 3);

        // Single-iteration instance, back-to-back with consumer always ready
        for (int n = 0; n < 1000; n++) begin
            na = rnd_nr(); ra = rnd_r(); nb = rnd_nr(); rb = rnd_r();
            if (n == 0) begin na = all_nr; ra = all_r; nb = all_nr; rb = all_r; end
            exp = model(na, ra, nb, rb);
            nr_a1 = na; r_a1 = ra; nr_b1 = nb; r_b1 = rb;
            cnt = 0;
            while (!in_ready1 && cnt < 10) begin @(posedge clk); #1; cnt++; end
            check("t6 ready", RES'(in_ready1), RES'(1));
            in_valid1 = 1'b1;
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            nr_a1 = rnd_nr(); nr_b1 = rnd_nr();
            cnt = 0;
            while (!out_valid1 && cnt < 10) begin @(posedge clk); #1; cnt++; end
            check("t6 latency", RES'(cnt), RES'(LAT1));
            tot = part_nr1 + part_r1;
            check("t6 product", tot, exp);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
